// File: rtl/pim_weight_readback.sv
// Streams a 256-bit CAM/CIM weight snapshot back out as sixteen 32-bit words.
// The nibble packing inverts the weight-load interleave, so word k reads back as written.
module pim_weight_readback (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [255:0] i_cam_data,
    input  logic [255:0] i_cim_data,
    input  logic         i_ready,
    output logic [31:0]  o_data,
    output logic         o_valid,
    output logic         o_last,
    output logic [3:0]   o_index,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [255:0] cam_q, cam_d;
    logic [255:0] cim_q, cim_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;

    logic         streaming;
    logic         xfer;
    logic [7:0]   slice_base;
    logic [15:0]  cam_slice;
    logic [15:0]  cim_slice;

    // Word k takes the 16 bits starting at 255-16k, i.e. slice (15-k) counted from the LSB.
    function automatic logic [31:0] interleave(input logic [15:0] cam_s, input logic [15:0] cim_s);
        return {cam_s[15:12], cim_s[15:12], cam_s[11:8], cim_s[11:8],
                cam_s[7:4],   cim_s[7:4],   cam_s[3:0],  cim_s[3:0]};
    endfunction

    assign streaming  = (state_q == STREAM);
    assign xfer       = streaming && i_ready;
    assign slice_base = {~cnt_q, 4'b0000};
    assign cam_slice  = cam_q[slice_base +: 16];
    assign cim_slice  = cim_q[slice_base +: 16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cam_d   = cam_q;
        cim_d   = cim_q;
        done_d  = 1'b0;
        if (i_abort) begin
            // Abort wins over start and over a same-cycle transfer; snapshot is kept.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        cam_d   = i_cam_data;
                        cim_d   = i_cim_data;
                        cnt_d   = 4'd0;
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (cnt_q == 4'd15) begin
                            state_d = IDLE;
                            cnt_d   = 4'd0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cam_q   <= '0;
            cim_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cam_q   <= cam_d;
            cim_q   <= cim_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        o_valid = streaming;
        o_busy  = streaming;
        o_done  = done_q;
        o_data  = streaming ? interleave(cam_slice, cim_slice) : 32'd0;
        o_index = streaming ? cnt_q : 4'd0;
        o_last  = streaming && (cnt_q == 4'd15);
    end

endmodule

// File: tb/tb_pim_weight_readback.sv
// Directed bench for pim_weight_readback: a vector table for single-cycle behaviour
// plus hand-written sequences for sweep, backpressure, isolation, abort and reset.
module tb_pim_weight_readback;

    logic         i_clk = 1'b0;
    logic         i_rst, i_start, i_abort, i_ready;
    logic [255:0] i_cam_data, i_cim_data;
    logic [31:0]  o_data;
    logic         o_valid, o_last, o_busy, o_done;
    logic [3:0]   o_index;

    int total  = 0;
    int passed = 0;

    always #5 i_clk = ~i_clk;

    pim_weight_readback dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_cam_data(i_cam_data), .i_cim_data(i_cim_data), .i_ready(i_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_index(o_index),
        .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        logic         rst, start, abort, ready;
        logic [255:0] cam, cim;
        logic         e_valid;
        logic [31:0]  e_data;
        logic [3:0]   e_idx;
        logic         e_last, e_busy, e_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_idle(input string nm, input logic exp_done);
        chk({nm, " valid"}, {31'd0, o_valid}, 32'd0);
        chk({nm, " busy"},  {31'd0, o_busy},  32'd0);
        chk({nm, " index"}, {28'd0, o_index}, 32'd0);
        chk({nm, " data"},  o_data, 32'd0);
        chk({nm, " last"},  {31'd0, o_last},  32'd0);
        chk({nm, " done"},  {31'd0, o_done},  {31'd0, exp_done});
    endtask

    // Re-pack the observed word through the load interleave and compare with the source slice.
    task automatic chk_word(input string nm, input int k, input logic [255:0] cam, input logic [255:0] cim);
        logic [255:0] cs, ms;
        logic [15:0]  cam_rb, cim_rb;
        cs = cam >> (240 - 16 * k);
        ms = cim >> (240 - 16 * k);
        cam_rb = {o_data[31:28], o_data[23:20], o_data[15:12], o_data[7:4]};
        cim_rb = {o_data[27:24], o_data[19:16], o_data[11:8],  o_data[3:0]};
        chk({nm, " valid"}, {31'd0, o_valid}, 32'd1);
        chk({nm, " index"}, {28'd0, o_index}, k);
        chk({nm, " last"},  {31'd0, o_last},  (k == 15) ? 32'd1 : 32'd0);
        chk({nm, " cam"},   {16'd0, cam_rb},  {16'd0, cs[15:0]});
        chk({nm, " cim"},   {16'd0, cim_rb},  {16'd0, ms[15:0]});
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Drives a start for one edge; returns at the negedge of cycle T+1.
    task automatic start_stream(input logic [255:0] cam, input logic [255:0] cim);
        i_start = 1'b1; i_cam_data = cam; i_cim_data = cim;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    logic [255:0] ca, ma, cb;
    logic [31:0]  held;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, {16'h1234, 240'd0}, {16'h5678, 240'd0},
                    1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 256'd0, 256'd0,
                    1'b1, 32'h15263748, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 256'd0, 256'd0,
                    1'b1, 32'h15263748, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 256'd0, 256'd0,
                    1'b1, 32'h0, 4'd1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, {256{1'b1}}, 256'd0,
                    1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 256'd0, 256'd0,
                    1'b1, 32'hF0F0F0F0, 4'd0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 256'd0, 256'd0,
                    1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 256'd0, 256'd0,
                    1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0};

        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
        i_cam_data = '0; i_cim_data = '0;
        repeat (2) @(negedge i_clk);

        // Table: check outputs of this cycle, then drive inputs for the next edge.
        for (int v = 0; v < 8; v++) begin
            chk($sformatf("vec%0d valid", v), {31'd0, o_valid}, {31'd0, vecs[v].e_valid});
            chk($sformatf("vec%0d data", v),  o_data, vecs[v].e_data);
            chk($sformatf("vec%0d index", v), {28'd0, o_index}, {28'd0, vecs[v].e_idx});
            chk($sformatf("vec%0d last", v),  {31'd0, o_last}, {31'd0, vecs[v].e_last});
            chk($sformatf("vec%0d busy", v),  {31'd0, o_busy}, {31'd0, vecs[v].e_busy});
            chk($sformatf("vec%0d done", v),  {31'd0, o_done}, {31'd0, vecs[v].e_done});
            i_rst = vecs[v].rst; i_start = vecs[v].start; i_abort = vecs[v].abort;
            i_ready = vecs[v].ready; i_cam_data = vecs[v].cam; i_cim_data = vecs[v].cim;
            @(negedge i_clk);
        end

        // Full sweep with random data.
        ca = rand256(); ma = rand256();
        i_ready = 1'b1;
        start_stream(ca, ma);
        for (int k = 0; k < 16; k++) begin
            chk_word($sformatf("sweep w%0d", k), k, ca, ma);
            chk($sformatf("sweep w%0d nodone", k), {31'd0, o_done}, 32'd0);
            @(negedge i_clk);
        end
        chk("sweep done T+17", {31'd0, o_done}, 32'd1);
        chk("sweep idle T+17", {31'd0, o_valid}, 32'd0);

        // Start in the done cycle, then backpressure at index 5.
        cb = rand256();
        start_stream(cb, ca);
        chk("done-cycle start done drop", {31'd0, o_done}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk_word($sformatf("bp w%0d", k), k, cb, ca);
            @(negedge i_clk);
        end
        chk_word("bp w5", 5, cb, ca);
        held = o_data;
        i_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clk);
            chk($sformatf("bp hold%0d data", s), o_data, held);
            chk($sformatf("bp hold%0d index", s), {28'd0, o_index}, 32'd5);
            chk($sformatf("bp hold%0d valid", s), {31'd0, o_valid}, 32'd1);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        for (int k = 6; k < 16; k++) begin
            chk_word($sformatf("bp w%0d", k), k, cb, ca);
            @(negedge i_clk);
        end
        chk("bp done", {31'd0, o_done}, 32'd1);
        @(negedge i_clk);
        chk("bp done one cycle", {31'd0, o_done}, 32'd0);

        // Snapshot isolation with an ignored start at index 3.
        start_stream(ca, ma);
        for (int k = 0; k < 16; k++) begin
            chk_word($sformatf("iso w%0d", k), k, ca, ma);
            if (k == 3) begin
                i_start = 1'b1; i_cam_data = ~ca; i_cim_data = ~ma;
            end else begin
                i_start = 1'b0;
            end
            @(negedge i_clk);
        end
        chk("iso done", {31'd0, o_done}, 32'd1);
        @(negedge i_clk);

        // Abort together with ready at index 9.
        start_stream(cb, ma);
        for (int k = 0; k < 9; k++) @(negedge i_clk);
        chk_word("abort w9", 9, cb, ma);
        i_abort = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        chk_idle("abort next", 1'b0);
        @(negedge i_clk);
        chk("abort no done", {31'd0, o_done}, 32'd0);
        start_stream(ca, cb);
        chk_word("abort restart w0", 0, ca, cb);

        // Reset at index 12, then a zero stream.
        for (int k = 0; k < 12; k++) @(negedge i_clk);
        chk_word("rst w12", 12, ca, cb);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk_idle("rst next", 1'b0);
        start_stream(256'd0, 256'd0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("zero w%0d data", k), o_data, 32'd0);
            chk($sformatf("zero w%0d index", k), {28'd0, o_index}, k);
            @(negedge i_clk);
        end
        chk("zero done", {31'd0, o_done}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pim_weight_readback.md
# pim_weight_readback

Serialises the two 256-bit CAM/CIM weight vectors held by the PIM wrapper back into a stream of sixteen 32-bit bus words. Its packing is the exact inverse of the weight-load nibble interleave, so a word read back equals the word originally written at the same index. It sits between the PIM weight storage and the wrapper's bus read path. It is used for weight verification and debug readback.

## Interface
- Parameters: none; geometry is fixed at 16 words × 32 bits per 256-bit CAM/CIM pair.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset: synchronous, active-high.
- i_start  in  1  snapshot request; honoured only in IDLE.
- i_abort  in  1  terminate the stream immediately.
- i_cam_data  in  256  CAM weight vector, sampled on an accepted start.
- i_cim_data  in  256  CIM weight vector, sampled on an accepted start.
- i_ready  in  1  consumer accepts o_data this cycle.
- o_data  out  32  current packed word; 0 when o_valid=0.
- o_valid  out  1  o_data is valid.
- o_last  out  1  current word is index 15; qualified by o_valid.
- o_index  out  4  index of current word.
- o_busy  out  1  high in STREAM.
- o_done  out  1  one-cycle pulse after word 15 is accepted.

## Operation
- States: IDLE and STREAM. Snapshot registers cam_q[255:0] and cim_q[255:0]. Word counter cnt[3:0].
- IDLE with i_start=1 and i_abort=0:
  - cam_q <= i_cam_data, cim_q <= i_cim_data.
  - cnt <= 0, go to STREAM.
- STREAM:
  - o_valid=1, o_index=cnt, o_last=(cnt==15).
  - Packing for word k, base b=255-16k:
    - o_data[31:28]=cam_q[b -: 4], o_data[27:24]=cim_q[b -: 4]
    - o_data[23:20]=cam_q[b-4 -: 4], o_data[19:16]=cim_q[b-4 -: 4]
    - o_data[15:12]=cam_q[b-8 -: 4], o_data[11:8]=cim_q[b-8 -: 4]
    - o_data[7:4]=cam_q[b-12 -: 4], o_data[3:0]=cim_q[b-12 -: 4]
  - Every index k covers exactly 16 contiguous bits of each vector. No overlapping or short slices.
  - Handshake: a transfer occurs when o_valid && i_ready.
    - cnt<15: cnt increments.
    - cnt==15: go to IDLE, o_done <= 1 next cycle, cnt <= 0.
  - No transfer: o_data, o_index and o_last hold stable. o_valid must not drop without a transfer or abort.
- i_start in STREAM is ignored. The snapshot is not updated.
- i_abort: from any state, go to IDLE, cnt <= 0, no o_done. Snapshot contents are retained.
  - i_abort has priority over i_start and over a same-cycle transfer.
- Snapshot isolation: changes on i_cam_data/i_cim_data after the start cycle do not affect the stream.
- In IDLE: o_valid=0, o_last=0, o_data=0, o_index=0, o_busy=0.

## Timing
- Reset: state IDLE, cnt=0, cam_q=cim_q=0, o_done=0. Every output is 0 in the cycle after i_rst is sampled high.
- i_rst mid-stream behaves as an abort plus snapshot clear; no o_done.
- Latency: start sampled at edge T; word 0 is valid in cycle T+1.
- Throughput: with i_ready held high, one word per cycle. Sixteen words occupy cycles T+1..T+16. o_done is high in cycle T+17.
- o_done is registered. It is high for exactly one cycle, in which the block is already in IDLE. An i_start in that cycle is accepted; word 0 of the new stream appears one cycle later.
- o_data, o_last and o_index are combinational from cam_q, cim_q and cnt. There is no additional pipeline stage.

## Test plan
- Inverse check: cam[255:240]=16'h1234, cim[255:240]=16'h5678, start with i_ready=1 -> word 0 = 32'h15263748 in cycle T+1, o_index=0.
- Full sweep:
  - Load random cam/cim, drain with i_ready=1.
  - Required: 16 consecutive words. Each word re-packed through the weight-load interleave reproduces the matching 16-bit slice.
  - o_last only on index 15; o_done in cycle T+17.
- Backpressure: hold i_ready=0 for 3 cycles at index 5 -> o_data, o_index=5 and o_valid stable throughout; index 6 follows the first ready cycle.
- Snapshot isolation and ignored start: change i_cam_data and pulse i_start at index 3 -> remaining words still reflect the original snapshot; index sequence is unchanged.
- Abort: assert i_abort together with i_ready at index 9 -> next cycle o_valid=0, o_busy=0, o_index=0, no o_done. A new start then restarts from index 0.
- Reset mid-stream at index 12 -> all outputs 0. A following start with zero inputs yields sixteen 32'h0 words.
